axi4_burst_master_param: RTL and testbench

Parametrised AXI4 full-protocol burst master, successor to the fixed-length controller. A start pulse launches a programmable number of INCR bursts at a runtime base address and burst length. Each burst is written with a deterministic pattern, then read back and compared. It sits between a control/status front end and the AXI interconnect and serves as the team's traffic generator and link checker.

---
 rtl/axi4_burst_master_param.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_axi4_burst_master_param.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_master_param.sv
// axi4_burst_master_param: AXI4 INCR burst traffic generator and link checker.
// A run writes cfg_num_bursts bursts of (cfg_len+1) beats carrying
// PATTERN_SEED + global beat index. It then reads the same bursts back and
// counts mismatching beats and non-OKAY responses. Only one AXI transaction
// is outstanding at any time.
module axi4_burst_master_param #(
  parameter int          ID_WIDTH     = 4,
  parameter int          ADDR_WIDTH   = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter int          MAX_BURSTS_W = 8,
  parameter logic [31:0] PATTERN_SEED = 32'h0000_0001
) (
  input  logic                    m00_axi_aclk,
  input  logic                    m00_axi_areset,
  input  logic                    init_txn,
  input  logic [ADDR_WIDTH-1:0]   cfg_base_addr,
  input  logic [7:0]              cfg_len,
  input  logic [MAX_BURSTS_W-1:0] cfg_num_bursts,
  output logic                    busy,
  output logic                    txn_done,
  output logic                    error,
  output logic [15:0]             err_count,
  output logic [ID_WIDTH-1:0]     m00_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic [7:0]              m00_axi_awlen,
  output logic [2:0]              m00_axi_awsize,
  output logic [1:0]              m00_axi_awburst,
  output logic                    m00_axi_awvalid,
  input  logic                    m00_axi_awready,
  output logic [DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic                    m00_axi_wlast,
  output logic                    m00_axi_wvalid,
  input  logic                    m00_axi_wready,
  input  logic [ID_WIDTH-1:0]     m00_axi_bid,
  input  logic [1:0]              m00_axi_bresp,
  input  logic                    m00_axi_bvalid,
  output logic                    m00_axi_bready,
  output logic [ID_WIDTH-1:0]     m00_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m00_axi_araddr,
  output logic [7:0]              m00_axi_arlen,
  output logic [2:0]              m00_axi_arsize,
  output logic [1:0]              m00_axi_arburst,
  output logic                    m00_axi_arvalid,
  input  logic                    m00_axi_arready,
  input  logic [ID_WIDTH-1:0]     m00_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m00_axi_rdata,
  input  logic [1:0]              m00_axi_rresp,
  input  logic                    m00_axi_rlast,
  input  logic                    m00_axi_rvalid,
  output logic                    m00_axi_rready
);

  localparam int         DBYTES = DATA_WIDTH / 8;
  localparam logic [2:0] SIZE   = 3'($clog2(DBYTES));

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
  } state_t;

  state_t                  state_q;
  logic                    init_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [7:0]              len_q;
  logic [MAX_BURSTS_W-1:0] num_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [MAX_BURSTS_W-1:0] burst_q;
  logic [7:0]              beat_q;
  logic [31:0]             g_q;
  logic [11:0]             chk_off_q;
  logic [15:0]             err_cnt_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    awvalid_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic                    wvalid_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    wlast_q;
  logic                    bready_q;
  logic                    arvalid_q;
  logic [ADDR_WIDTH-1:0]   araddr_q;
  logic                    rready_q;

  logic [12:0]             burst_bytes;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [MAX_BURSTS_W-1:0] burst_d;
  logic [7:0]              beat_d;
  logic [31:0]             g_d;
  logic                    burst_last;
  logic                    beat_last;
  logic                    crosses_4k;
  logic                    rd_bad;
  logic                    unused_ids;

  // Beat payload: seed plus global beat index, zero-extended to the bus width.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [31:0] g);
    logic [31:0] s;
    s = PATTERN_SEED + g;
    return DATA_WIDTH'(s);
  endfunction

  // Error counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Bytes per burst; at most 256 beats * 16 bytes = 4096, fits 13 bits.
  assign burst_bytes = ({5'd0, len_q} + 13'd1) << SIZE;
  assign addr_d      = addr_q + ADDR_WIDTH'(burst_bytes);
  assign burst_d     = burst_q + MAX_BURSTS_W'(1);
  assign beat_d      = beat_q + 8'd1;
  assign g_d         = g_q + 32'd1;
  assign burst_last  = (burst_d == num_q);
  assign beat_last   = (beat_q == len_q);
  // Only the in-page offset matters for the 4 KB rule, so the pre-check
  // walks a 12-bit offset instead of the full address.
  assign crosses_4k  = ({1'b0, chk_off_q} + burst_bytes) > 13'd4096;
  // A beat with several faults still counts once.
  assign rd_bad      = (m00_axi_rdata != pattern(g_q)) || (m00_axi_rresp != 2'b00) ||
                       (m00_axi_rlast != beat_last);
  assign unused_ids  = ^{m00_axi_bid, m00_axi_rid};

  assign busy            = busy_q;
  assign txn_done        = done_q;
  assign err_count       = err_cnt_q;
  assign error           = (err_cnt_q != 16'd0);
  assign m00_axi_awid    = '0;
  assign m00_axi_awaddr  = awaddr_q;
  assign m00_axi_awlen   = len_q;
  assign m00_axi_awsize  = SIZE;
  assign m00_axi_awburst = 2'b01;
  assign m00_axi_awvalid = awvalid_q;
  assign m00_axi_wdata   = wdata_q;
  assign m00_axi_wstrb   = '1;
  assign m00_axi_wlast   = wlast_q;
  assign m00_axi_wvalid  = wvalid_q;
  assign m00_axi_bready  = bready_q;
  assign m00_axi_arid    = '0;
  assign m00_axi_araddr  = araddr_q;
  assign m00_axi_arlen   = len_q;
  assign m00_axi_arsize  = SIZE;
  assign m00_axi_arburst = 2'b01;
  assign m00_axi_arvalid = arvalid_q;
  assign m00_axi_rready  = rready_q;

  // Run sequencer: config check, write phase, read-back phase, completion.
  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) begin
      state_q   <= S_IDLE;
      init_q    <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      num_q     <= '0;
      addr_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      g_q       <= '0;
      chk_off_q <= '0;
      err_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      awvalid_q <= 1'b0;
      awaddr_q  <= '0;
      wvalid_q  <= 1'b0;
      wdata_q   <= '0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      rready_q  <= 1'b0;
    end else begin
      init_q <= init_txn;
      case (state_q)
        S_IDLE: begin
          if (init_txn && !init_q) begin
            base_q    <= cfg_base_addr;
            len_q     <= cfg_len;
            num_q     <= cfg_num_bursts;
            addr_q    <= cfg_base_addr;
            chk_off_q <= cfg_base_addr[11:0];
            burst_q   <= '0;
            beat_q    <= '0;
            g_q       <= '0;
            err_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_CHECK;
          end
        end
        // One burst per cycle is screened for a 4 KB crossing before any
        // bus activity, so an illegal run never touches the interconnect.
        S_CHECK: begin
          if (num_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (crosses_4k) begin
            err_cnt_q <= 16'd1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else if (burst_last) begin
            burst_q   <= '0;
            awvalid_q <= 1'b1;
            awaddr_q  <= addr_q;
            state_q   <= S_WR_ADDR;
          end else begin
            burst_q   <= burst_d;
            chk_off_q <= chk_off_q + burst_bytes[11:0];
          end
        end
        S_WR_ADDR: begin
          if (m00_axi_awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wdata_q   <= pattern(g_q);
            wlast_q   <= (len_q == 8'd0);
            beat_q    <= '0;
            state_q   <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (m00_axi_wready) begin
            g_q <= g_d;
            if (beat_last) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= S_WR_RESP;
            end else begin
              beat_q  <= beat_d;
              wdata_q <= pattern(g_d);
              wlast_q <= (beat_d == len_q);
            end
          end
        end
        S_WR_RESP: begin
          if (m00_axi_bvalid) begin
            bready_q <= 1'b0;
            if (m00_axi_bresp != 2'b00) err_cnt_q <= sat_inc(err_cnt_q);
            if (burst_last) begin
              burst_q   <= '0;
              addr_q    <= base_q;
              g_q       <= '0;
              arvalid_q <= 1'b1;
              araddr_q  <= base_q;
              state_q   <= S_RD_ADDR;
            end else begin
              burst_q   <= burst_d;
              addr_q    <= addr_d;
              awvalid_q <= 1'b1;
              awaddr_q  <= addr_d;
              state_q   <= S_WR_ADDR;
            end
          end
        end
        S_RD_ADDR: begin
          if (m00_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= '0;
            state_q   <= S_RD_DATA;
          end
        end
        // The burst length comes from the local beat count; rlast is only
        // checked, never trusted to end the burst.
        S_RD_DATA: begin
          if (m00_axi_rvalid) begin
            g_q    <= g_d;
            beat_q <= beat_d;
            if (rd_bad) err_cnt_q <= sat_inc(err_cnt_q);
            if (beat_last) begin
              rready_q <= 1'b0;
              if (burst_last) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                burst_q   <= burst_d;
                addr_q    <= addr_d;
                arvalid_q <= 1'b1;
                araddr_q  <= addr_d;
                state_q   <= S_RD_ADDR;
              end
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_burst_master_param.sv
// tb_axi4_burst_master_param: AXI slave responder with memory plus
// per-scenario tasks comparing observed bus traffic against expected queues.
`timescale 1ns/1ps
module tb_axi4_burst_master_param;

  localparam int IW = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_txn;
  logic [AW-1:0] cfg_base_addr;
  logic [7:0]    cfg_len;
  logic [7:0]    cfg_num_bursts;
  logic          busy, txn_done, error;
  logic [15:0]   err_count;
  logic [IW-1:0] awid, arid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst;
  logic          awvalid, awready, arvalid, arready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          wlast, wvalid, wready;
  logic [IW-1:0] bid, rid;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready;
  logic [DW-1:0] rdata;
  logic          rlast, rvalid, rready;

  initial forever #5 clk = ~clk;

  axi4_burst_master_param dut (
    .m00_axi_aclk(clk), .m00_axi_areset(rst), .init_txn(init_txn),
    .cfg_base_addr(cfg_base_addr), .cfg_len(cfg_len), .cfg_num_bursts(cfg_num_bursts),
    .busy(busy), .txn_done(txn_done), .error(error), .err_count(err_count),
    .m00_axi_awid(awid), .m00_axi_awaddr(awaddr), .m00_axi_awlen(awlen),
    .m00_axi_awsize(awsize), .m00_axi_awburst(awburst), .m00_axi_awvalid(awvalid),
    .m00_axi_awready(awready), .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
    .m00_axi_wlast(wlast), .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
    .m00_axi_bid(bid), .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
    .m00_axi_arid(arid), .m00_axi_araddr(araddr), .m00_axi_arlen(arlen),
    .m00_axi_arsize(arsize), .m00_axi_arburst(arburst), .m00_axi_arvalid(arvalid),
    .m00_axi_arready(arready), .m00_axi_rid(rid), .m00_axi_rdata(rdata),
    .m00_axi_rresp(rresp), .m00_axi_rlast(rlast), .m00_axi_rvalid(rvalid),
    .m00_axi_rready(rready)
  );

  int total = 0;
  int bad   = 0;

  // Scenario knobs, written only by the test sequence.
  bit          stall_en = 1'b0;
  bit          corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = 32'h0;
  bit          bresp_err_once = 1'b0;
  bit          clr_tog = 1'b0;

  // Observations, written only by the responder.
  logic [31:0] obs_aw[$];
  logic [7:0]  obs_awlen[$];
  logic [31:0] obs_ar[$];
  logic [31:0] obs_w[$];
  bit          obs_wlast[$];
  int          obs_wcyc[$];
  int          stab_err = 0;
  int          any_valid = 0;
  int          cyc = 0;

  // Expectations, written only by the test sequence.
  logic [31:0] exp_aw[$];
  logic [31:0] exp_ar[$];
  logic [31:0] exp_w[$];

  logic [31:0] mem [int unsigned];

  // Slave responder: acts on the falling edge so every decision it takes
  // is what the DUT sees at the next rising edge.
  initial begin : responder
    bit          clr_seen, aw_pend, w_pend, ar_pend, b_pending, b_hs, r_active, r_hs, wl_prev;
    logic [31:0] aw_prev, ar_prev, w_prev, cur_waddr, r_addr, a;
    int          wbeat, r_len, r_beat;
    logic [31:0] rq_addr[$];
    int          rq_len[$];
    clr_seen = 1'b0; aw_pend = 0; w_pend = 0; ar_pend = 0; b_pending = 0; b_hs = 0;
    r_active = 0; r_hs = 0; wl_prev = 0; aw_prev = 0; ar_prev = 0; w_prev = 0;
    cur_waddr = 0; r_addr = 0; wbeat = 0; r_len = 0; r_beat = 0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; bresp = 0; bid = '0;
    rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (clr_tog != clr_seen) begin
        clr_seen = clr_tog;
        obs_aw.delete(); obs_awlen.delete(); obs_ar.delete();
        obs_w.delete(); obs_wlast.delete(); obs_wcyc.delete();
        stab_err = 0; any_valid = 0;
      end
      if (rst) begin
        aw_pend = 0; w_pend = 0; ar_pend = 0; b_pending = 0; b_hs = 0;
        r_active = 0; r_hs = 0; rq_addr.delete(); rq_len.delete();
        bvalid = 0; rvalid = 0; rlast = 0;
      end else begin
        if (awvalid || wvalid || arvalid || bready || rready) any_valid++;
        awready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        wready  = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        arready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (aw_pend && (!awvalid || awaddr !== aw_prev)) stab_err++;
        if (w_pend && (!wvalid || wdata !== w_prev || wlast !== wl_prev)) stab_err++;
        if (ar_pend && (!arvalid || araddr !== ar_prev)) stab_err++;
        // B channel (before W so a response follows the last beat by a cycle)
        if (b_hs) begin bvalid = 0; b_hs = 0; end
        if (b_pending) begin
          bvalid = 1; bresp = bresp_err_once ? 2'b10 : 2'b00; b_pending = 0;
        end
        b_hs = bvalid && bready;
        // AW channel
        if (awvalid && awready) begin
          obs_aw.push_back(awaddr); obs_awlen.push_back(awlen);
          cur_waddr = awaddr; wbeat = 0; aw_pend = 0;
        end else begin
          aw_pend = awvalid; aw_prev = awaddr;
        end
        // W channel
        if (wvalid && wready) begin
          obs_w.push_back(wdata); obs_wlast.push_back(wlast); obs_wcyc.push_back(cyc);
          mem[cur_waddr + 32'(wbeat * 4)] = wdata;
          wbeat++;
          if (wlast) b_pending = 1;
          w_pend = 0;
        end else begin
          w_pend = wvalid; w_prev = wdata; wl_prev = wlast;
        end
        // R channel (before AR so data trails the address handshake)
        if (r_hs) begin
          r_beat++; rvalid = 0; r_hs = 0;
          if (r_beat > r_len) r_active = 0;
        end
        if (!r_active && rq_addr.size() > 0) begin
          r_addr = rq_addr.pop_front(); r_len = rq_len.pop_front(); r_beat = 0; r_active = 1;
        end
        if (r_active && !rvalid) rvalid = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (rvalid) begin
          a = r_addr + 32'(r_beat * 4);
          rdata = mem.exists(a) ? mem[a] : 32'h0;
          if (corrupt_en && a == corrupt_addr) rdata = rdata ^ 32'h0000_0100;
          rlast = (r_beat == r_len);
        end else begin
          rlast = 0;
        end
        r_hs = rvalid && rready;
        // AR channel
        if (arvalid && arready) begin
          obs_ar.push_back(araddr); rq_addr.push_back(araddr); rq_len.push_back(int'(arlen));
          ar_pend = 0;
        end else begin
          ar_pend = arvalid; ar_prev = araddr;
        end
      end
    end
  end

  // Drives a new run and pushes the bench's own expectation of the traffic.
  task automatic start_run(input logic [31:0] base, input logic [7:0] len, input logic [7:0] num);
    int bytes, g;
    bit legal;
    logic [31:0] a;
    exp_aw.delete(); exp_ar.delete(); exp_w.delete();
    bytes = (int'(len) + 1) * (DW / 8);
    legal = (num != 0);
    for (int k = 0; k < int'(num); k++) begin
      a = base + 32'(k * bytes);
      if (int'(a % 4096) + bytes > 4096) legal = 0;
    end
    g = 0;
    if (legal) begin
      for (int k = 0; k < int'(num); k++) begin
        a = base + 32'(k * bytes);
        exp_aw.push_back(a); exp_ar.push_back(a);
        for (int b = 0; b <= int'(len); b++) begin
          exp_w.push_back(32'h1 + 32'(g)); g++;
        end
      end
    end
    clr_tog = ~clr_tog;
    cfg_base_addr = base; cfg_len = len; cfg_num_bursts = num;
    init_txn = 1'b1;
  endtask

  task automatic wait_done(output int lat, output bit ok);
    ok = 0; lat = 0;
    for (int k = 1; k <= 4000 && !ok; k++) begin
      @(negedge clk); #1;
      if (txn_done === 1'b1) begin ok = 1; lat = k; end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin @(negedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1; init_txn = 1'b0; cfg_base_addr = '0; cfg_len = '0; cfg_num_bursts = '0;
    idle(3);
    total++; if ({awvalid, wvalid, wlast, arvalid, bready, rready} !== 6'b0) begin
      bad++; $display("FAIL reset_valids: got %b want 000000", {awvalid, wvalid, wlast, arvalid, bready, rready}); end
    total++; if ({busy, txn_done, error} !== 3'b0) begin
      bad++; $display("FAIL reset_status: busy/done/error got %b want 000", {busy, txn_done, error}); end
    total++; if (err_count !== 16'd0) begin
      bad++; $display("FAIL reset_errcnt: got %0d want 0", err_count); end
    total++; if (awaddr !== 32'h0 || araddr !== 32'h0 || wdata !== 32'h0) begin
      bad++; $display("FAIL reset_addrdata: aw=%h ar=%h w=%h want 0", awaddr, araddr, wdata); end
    total++; if (awsize !== 3'd2 || awburst !== 2'b01 || wstrb !== 4'hF || awid !== '0) begin
      bad++; $display("FAIL reset_consts: size=%0d burst=%b strb=%h id=%0d", awsize, awburst, wstrb, awid); end
    rst = 1'b0;
    idle(2);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_single_zero_wait();
    int lat; bit ok;
    stall_en = 0; corrupt_en = 0; bresp_err_once = 0;
    start_run(32'h4000_0000, 8'd15, 8'd1);
    wait_done(lat, ok);
    init_txn = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL t1_done: txn_done seen=0 want 1"); end
    total++; if (busy !== 1'b0 || error !== 1'b0 || err_count !== 16'd0) begin
      bad++; $display("FAIL t1_status: busy=%b error=%b err_count=%0d want 0/0/0", busy, error, err_count); end
    total++; if (obs_aw.size() != 1 || obs_awlen.size() != 1) begin
      bad++; $display("FAIL t1_aw_count: got %0d want 1", obs_aw.size()); end
    else begin
      total++; if (obs_aw[0] !== exp_aw[0] || obs_awlen[0] !== 8'd15) begin
        bad++; $display("FAIL t1_aw: addr=%h len=%0d want %h/15", obs_aw[0], obs_awlen[0], exp_aw[0]); end
    end
    total++; if (obs_w.size() != exp_w.size()) begin
      bad++; $display("FAIL t1_w_count: got %0d want %0d", obs_w.size(), exp_w.size()); end
    else begin
      for (int i = 0; i < exp_w.size(); i++) begin
        total++; if (obs_w[i] !== exp_w[i] || obs_wlast[i] !== (i == 15)) begin
          bad++; $display("FAIL t1_wbeat%0d: data=%h last=%b want %h/%b", i, obs_w[i], obs_wlast[i], exp_w[i], i == 15); end
        total++; if (obs_wcyc[i] - obs_wcyc[0] != i) begin
          bad++; $display("FAIL t1_wcycle%0d: offset=%0d want %0d", i, obs_wcyc[i] - obs_wcyc[0], i); end
      end
    end
    total++; if (obs_ar.size() != 1 || obs_ar[0] !== exp_ar[0]) begin
      bad++; $display("FAIL t1_ar: count=%0d want 1 at %h", obs_ar.size(), exp_ar[0]); end
    idle(1);
    total++; if (txn_done !== 1'b0) begin bad++; $display("FAIL t1_pulse: txn_done=%b want 0", txn_done); end
    idle(2);
  endtask

  task automatic test_multi_stall();
    int lat; bit ok;
    stall_en = 1; corrupt_en = 0; bresp_err_once = 0;
    start_run(32'h4000_0000, 8'd3, 8'd4);
    wait_done(lat, ok);
    init_txn = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL t2_done: txn_done seen=0 want 1"); end
    total++; if (err_count !== 16'd0 || error !== 1'b0) begin
      bad++; $display("FAIL t2_err: err_count=%0d error=%b want 0/0", err_count, error); end
    total++; if (stab_err != 0) begin bad++; $display("FAIL t2_stable: violations=%0d want 0", stab_err); end
    total++; if (obs_aw.size() != exp_aw.size() || obs_ar.size() != exp_ar.size()) begin
      bad++; $display("FAIL t2_addr_count: aw=%0d ar=%0d want %0d", obs_aw.size(), obs_ar.size(), exp_aw.size()); end
    else begin
      for (int i = 0; i < exp_aw.size(); i++) begin
        total++; if (obs_aw[i] !== exp_aw[i] || obs_awlen[i] !== 8'd3 || obs_ar[i] !== exp_ar[i]) begin
          bad++; $display("FAIL t2_addr%0d: aw=%h len=%0d ar=%h want %h/3", i, obs_aw[i], obs_awlen[i], obs_ar[i], exp_aw[i]); end
      end
    end
    total++; if (obs_w.size() != exp_w.size()) begin
      bad++; $display("FAIL t2_w_count: got %0d want %0d", obs_w.size(), exp_w.size()); end
    else begin
      for (int i = 0; i < exp_w.size(); i++) begin
        total++; if (obs_w[i] !== exp_w[i] || obs_wlast[i] !== (i % 4 == 3)) begin
          bad++; $display("FAIL t2_wbeat%0d: data=%h last=%b want %h/%b", i, obs_w[i], obs_wlast[i], exp_w[i], i % 4 == 3); end
      end
    end
    stall_en = 0;
    idle(2);
  endtask

  task automatic test_errors();
    int lat; bit ok;
    stall_en = 0; corrupt_en = 1; corrupt_addr = 32'h4000_0010; bresp_err_once = 1;
    start_run(32'h4000_0000, 8'd15, 8'd1);
    wait_done(lat, ok);
    init_txn = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL t3_done: txn_done seen=0 want 1"); end
    total++; if (err_count !== 16'd2) begin bad++; $display("FAIL t3_errcnt: got %0d want 2", err_count); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL t3_error: got %b want 1", error); end
    corrupt_en = 0; bresp_err_once = 0;
    idle(2);
  endtask

  task automatic test_4k_violation();
    int lat; bit ok;
    start_run(32'h4000_0FF0, 8'd7, 8'd1);
    wait_done(lat, ok);
    init_txn = 1'b0;
    total++; if (!ok || lat != 2) begin bad++; $display("FAIL t4_latency: seen=%b cycles=%0d want 1/2", ok, lat); end
    total++; if (error !== 1'b1 || err_count !== 16'd1) begin
      bad++; $display("FAIL t4_err: error=%b err_count=%0d want 1/1", error, err_count); end
    total++; if (any_valid != 0 || obs_aw.size() != exp_aw.size()) begin
      bad++; $display("FAIL t4_nobus: active cycles=%0d aw=%0d want 0/0", any_valid, obs_aw.size()); end
    idle(2);
  endtask

  task automatic test_reset_mid_burst();
    int lat; bit ok;
    stall_en = 0;
    start_run(32'h4000_0000, 8'd15, 8'd1);
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk); #1;
      if (obs_w.size() >= 3) ok = 1;
    end
    total++; if (!ok) begin bad++; $display("FAIL t5_reach: beats seen=%0d want 3", obs_w.size()); end
    rst = 1'b1; init_txn = 1'b0;
    #1;
    total++; if ({awvalid, wvalid, arvalid, bready, rready, busy} !== 6'b0) begin
      bad++; $display("FAIL t5_abort: valids/busy=%b want 000000", {awvalid, wvalid, arvalid, bready, rready, busy}); end
    idle(3);
    rst = 1'b0;
    idle(3);
    total++; if (txn_done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL t5_nodone: done=%b busy=%b want 0/0", txn_done, busy); end
    start_run(32'h4000_0000, 8'd15, 8'd1);
    wait_done(lat, ok);
    init_txn = 1'b0;
    total++; if (!ok || err_count !== 16'd0 || error !== 1'b0) begin
      bad++; $display("FAIL t5_rerun: done=%b err_count=%0d error=%b want 1/0/0", ok, err_count, error); end
    total++; if (obs_w.size() != exp_w.size()) begin
      bad++; $display("FAIL t5_w_count: got %0d want %0d", obs_w.size(), exp_w.size()); end
    else begin
      for (int i = 0; i < exp_w.size(); i++) begin
        total++; if (obs_w[i] !== exp_w[i]) begin
          bad++; $display("FAIL t5_wbeat%0d: data=%h want %h", i, obs_w[i], exp_w[i]); end
      end
    end
    idle(2);
  endtask

  task automatic test_zero_bursts();
    int lat, extra; bit ok;
    start_run(32'h4000_0000, 8'd3, 8'd0);
    wait_done(lat, ok);
    total++; if (!ok || lat != 2) begin bad++; $display("FAIL t6_done: seen=%b cycles=%0d want 1/2", ok, lat); end
    total++; if (error !== 1'b0 || err_count !== 16'd0) begin
      bad++; $display("FAIL t6_err: error=%b err_count=%0d want 0/0", error, err_count); end
    total++; if (any_valid != 0) begin bad++; $display("FAIL t6_nobus: active cycles=%0d want 0", any_valid); end
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (txn_done === 1'b1 || busy === 1'b1) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL t6_retrigger: active cycles=%0d want 0", extra); end
    init_txn = 1'b0;
    idle(2);
  endtask

  initial begin : main
    test_reset();
    test_single_zero_wait();
    test_multi_stall();
    test_errors();
    test_4k_violation();
    test_reset_mid_burst();
    test_zero_bursts();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
